// File: rtl/scan_capture_4led.sv
// scan_capture_4led: rebuilds a 4-digit BCD value from scanned 7-seg digit/anode traffic.
// Define SCAN_CAPTURE_BIN_OUT_EN to add the registered binary outputs bin_value/bin_valid.
module scan_capture_4led #(
    parameter int STABLE_FRAMES = 2,
    parameter int SCAN_HOLD_MAX = 255
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [3:0]  num,
    input  logic [3:0]  an_scan,
    input  logic [1:0]  sel_an,
    input  logic        err_clr,
    output logic [15:0] bcd_value,
    output logic        frame_valid,
`ifdef SCAN_CAPTURE_BIN_OUT_EN
    output logic [13:0] bin_value,
    output logic        bin_valid,
`endif
    output logic [2:0]  err_flags
);
    typedef enum logic {IDLE, COLLECT} state_t;
    localparam logic [8:0] HOLD_MAX = 9'(SCAN_HOLD_MAX);
    localparam logic [3:0] STABLE_MIN = 4'(STABLE_FRAMES);

    logic [3:0] num_q, an_q, stable_q, stable_d;
    logic [1:0] sel_q, sel_prev_q, exp_q, exp_d, last_q, last_d, idx;
    logic [7:0] hold_q, hold_d;
    logic [15:0] shadow_q, shadow_d, prev_q, prev_d, bcd_q, bcd_d, frame, mask;
    logic [2:0] err_q, err_d, set;
    logic fv_q, fv_d, committed_q, committed_d, valid, bad, same, complete;
    state_t state_q, state_d;

    always_comb begin
        valid = 1'b1;
        idx = 2'd0;
        case (an_q)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: valid = 1'b0;
        endcase
    end

    assign bad = !valid && an_q != 4'hF;
    assign same = state_q == COLLECT && idx == last_q && sel_q != 2'd0;
    assign mask = sel_q == 2'd3 ? 16'hFFFF : sel_q == 2'd2 ? 16'h0FFF : sel_q == 2'd1 ? 16'h00FF : 16'h000F;

    always_comb begin
        state_d = state_q;
        exp_d = exp_q;
        last_d = last_q;
        hold_d = hold_q;
        shadow_d = shadow_q;
        prev_d = prev_q;
        stable_d = stable_q;
        bcd_d = bcd_q;
        fv_d = 1'b0;
        committed_d = committed_q;
        set = 3'b000;
        complete = 1'b0;
        if (sel_q != sel_prev_q) begin
            state_d = IDLE;
            stable_d = 4'd0;
        end else if (bad) begin
            set[0] = 1'b1;
            state_d = IDLE;
        end else if (valid) begin
            if (idx > sel_q) begin
                set[2] = 1'b1;
                state_d = IDLE;
            end else if (num_q > 4'd9) begin
                set[1] = 1'b1;
                state_d = IDLE;
            end else if (same) begin
                shadow_d[{idx, 2'b00} +: 4] = num_q;
                if ({1'b0, hold_q} >= HOLD_MAX) begin
                    set[2] = 1'b1;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end else if ((state_q == COLLECT && idx == exp_q) || idx == 2'd0) begin
                // an index 0 out of turn is an error but still starts a fresh frame
                set[2] = state_q == COLLECT && idx != exp_q;
                shadow_d[{idx, 2'b00} +: 4] = num_q;
                hold_d = 8'd0;
                last_d = idx;
                state_d = COLLECT;
                complete = idx == sel_q;
                exp_d = complete ? 2'd0 : idx + 2'd1;
            end else if (state_q == COLLECT) begin
                set[2] = 1'b1;
                state_d = IDLE;
            end
        end
        frame = shadow_d & mask;
        if (complete) begin
            prev_d = frame;
            stable_d = frame != prev_q ? 4'd1 : stable_q == 4'hF ? 4'hF : stable_q + 4'd1;
            if (stable_d >= STABLE_MIN && (frame != bcd_q || !committed_q)) begin
                bcd_d = frame;
                fv_d = 1'b1;
                committed_d = 1'b1;
            end
        end
        if (|set) stable_d = 4'd0;
        err_d = err_clr ? set : err_q | set;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            num_q <= 4'd0;
            an_q <= 4'hF;
            sel_q <= 2'd0;
            sel_prev_q <= 2'd0;
            state_q <= IDLE;
            exp_q <= 2'd0;
            last_q <= 2'd0;
            hold_q <= 8'd0;
            shadow_q <= 16'd0;
            prev_q <= 16'd0;
            stable_q <= 4'd0;
            bcd_q <= 16'd0;
            fv_q <= 1'b0;
            committed_q <= 1'b0;
            err_q <= 3'd0;
        end else begin
            num_q <= num;
            an_q <= an_scan;
            sel_q <= sel_an;
            sel_prev_q <= sel_q;
            state_q <= state_d;
            exp_q <= exp_d;
            last_q <= last_d;
            hold_q <= hold_d;
            shadow_q <= shadow_d;
            prev_q <= prev_d;
            stable_q <= stable_d;
            bcd_q <= bcd_d;
            fv_q <= fv_d;
            committed_q <= committed_d;
            err_q <= err_d;
        end
    end

    assign bcd_value = bcd_q;
    assign frame_valid = fv_q;
    assign err_flags = err_q;

`ifdef SCAN_CAPTURE_BIN_OUT_EN
    logic [13:0] d3, d2, d1, d0, bin_d, bin_q;
    logic bin_valid_q;

    assign d3 = {10'd0, bcd_q[15:12]};
    assign d2 = {10'd0, bcd_q[11:8]};
    assign d1 = {10'd0, bcd_q[7:4]};
    assign d0 = {10'd0, bcd_q[3:0]};
    // 1000 = 1024-16-8, 100 = 64+32+4, 10 = 8+2
    assign bin_d = (d3 << 10) - (d3 << 4) - (d3 << 3) + (d2 << 6) + (d2 << 5) + (d2 << 2)
                 + (d1 << 3) + (d1 << 1) + d0;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            bin_q <= 14'd0;
            bin_valid_q <= 1'b0;
        end else begin
            bin_valid_q <= fv_q;
            if (fv_q) bin_q <= bin_d;
        end
    end

    assign bin_value = bin_q;
    assign bin_valid = bin_valid_q;
`endif
endmodule

// File: tb/tb_scan_capture_4led.sv
// tb_scan_capture_4led: directed-step bench for scan_capture_4led with immediate-assertion checks.
module tb_scan_capture_4led;
    logic clk_in = 1'b0;
    logic rst = 1'b1;
    logic [3:0] num = 4'd0;
    logic [3:0] an_scan = 4'hF;
    logic [1:0] sel_an = 2'd3;
    logic err_clr = 1'b0;
    logic [15:0] bcd_value;
    logic frame_valid;
    logic [2:0] err_flags;
`ifdef SCAN_CAPTURE_BIN_OUT_EN
    logic [13:0] bin_value;
    logic bin_valid;
`endif
    int errors = 0;
    int checks = 0;
    int fv_cnt = 0;
    int base;

    scan_capture_4led dut (
        .clk_in(clk_in),
        .rst(rst),
        .num(num),
        .an_scan(an_scan),
        .sel_an(sel_an),
        .err_clr(err_clr),
        .bcd_value(bcd_value),
        .frame_valid(frame_valid),
`ifdef SCAN_CAPTURE_BIN_OUT_EN
        .bin_value(bin_value),
        .bin_valid(bin_valid),
`endif
        .err_flags(err_flags)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) if (frame_valid === 1'b1) fv_cnt <= fv_cnt + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic digit(input int i, input logic [3:0] v);
        an_scan = ~(4'b0001 << i);
        num = v;
        tick(2);
        an_scan = 4'hF;
        tick(1);
    endtask

    task automatic frame(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] dv [4];
        dv = '{d0, d1, d2, d3};
        for (int i = 0; i <= int'(sel_an); i++) digit(i, dv[i]);
    endtask

    task automatic set_sel(input logic [1:0] s);
        sel_an = s;
        an_scan = 4'hF;
        tick(3);
    endtask

    initial begin
        tick(2);
        rst = 1'b0;
        chk("reset_bcd", bcd_value, 16'h0000);
        chk("reset_fv", {15'd0, frame_valid}, 16'd0);
        chk("reset_err", {13'd0, err_flags}, 16'd0);
`ifdef SCAN_CAPTURE_BIN_OUT_EN
        chk("reset_bin", {2'd0, bin_value}, 16'd0);
        chk("reset_binv", {15'd0, bin_valid}, 16'd0);
`endif
        tick(3);
        // four-digit scan 1234
        base = fv_cnt;
        frame(4, 3, 2, 1);
        chk("one_frame_no_commit", bcd_value, 16'h0000);
        frame(4, 3, 2, 1);
        chk("bcd_1234", bcd_value, 16'h1234);
        frame(4, 3, 2, 1);
        chk("pulses_1234", 16'(fv_cnt - base), 16'd1);
        chk("err_clean", {13'd0, err_flags}, 16'd0);
        // two-digit scan 57, then change to 58 with exact latency
        set_sel(2'd1);
        frame(7, 5, 0, 0);
        frame(7, 5, 0, 0);
        chk("bcd_0057", bcd_value, 16'h0057);
        base = fv_cnt;
        frame(8, 5, 0, 0);
        chk("58_first_frame", bcd_value, 16'h0057);
        digit(0, 8);
        an_scan = 4'b1101;
        num = 4'd5;
        tick(1);
        chk("lat_edge1_bcd", bcd_value, 16'h0057);
        chk("lat_edge1_fv", {15'd0, frame_valid}, 16'd0);
        tick(1);
        chk("lat_edge2_bcd", bcd_value, 16'h0058);
        chk("lat_edge2_fv", {15'd0, frame_valid}, 16'd1);
        an_scan = 4'hF;
        tick(1);
        chk("fv_one_cycle", {15'd0, frame_valid}, 16'd0);
        chk("pulses_58", 16'(fv_cnt - base), 16'd1);
        // bad anode pattern mid-frame
        set_sel(2'd3);
        digit(0, 4);
        an_scan = 4'b1100;
        tick(1);
        an_scan = 4'hF;
        tick(1);
        chk("pattern_err", {13'd0, err_flags}, 16'h0001);
        frame(4, 3, 2, 1);
        chk("after_pattern_1frame", bcd_value, 16'h0058);
        frame(4, 3, 2, 1);
        chk("after_pattern_commit", bcd_value, 16'h1234);
        chk("pattern_sticky", {13'd0, err_flags}, 16'h0001);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk("err_clr", {13'd0, err_flags}, 16'd0);
        // digit > 9 spoils the frame and the stability run
        frame(8, 7, 6, 5);
        frame(8, 7, 4'hC, 5);
        chk("digit_err", {13'd0, err_flags}, 16'h0002);
        frame(8, 7, 6, 5);
        chk("digit_err_no_commit", bcd_value, 16'h1234);
        frame(8, 7, 6, 5);
        chk("bcd_5678", bcd_value, 16'h5678);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        // out-of-order 0 -> 2
        digit(0, 4);
        digit(2, 2);
        chk("seq_err_order", {13'd0, err_flags}, 16'h0004);
        chk("seq_err_bcd_hold", bcd_value, 16'h5678);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        // anode held too long
        digit(0, 4);
        an_scan = 4'b1101;
        num = 4'd3;
        tick(250);
        chk("hold_250_ok", {13'd0, err_flags}, 16'd0);
        tick(50);
        chk("hold_300_err", {13'd0, err_flags}, 16'h0004);
        an_scan = 4'hF;
        tick(1);
        // reset mid-frame
        frame(4, 3, 2, 1);
        frame(4, 3, 2, 1);
        chk("pre_reset_bcd", bcd_value, 16'h1234);
        chk("pre_reset_err", {13'd0, err_flags}, 16'h0004);
        digit(0, 4);
        digit(1, 3);
        rst = 1'b1;
        tick(1);
        chk("rst_bcd", bcd_value, 16'h0000);
        chk("rst_err", {13'd0, err_flags}, 16'd0);
        chk("rst_fv", {15'd0, frame_valid}, 16'd0);
        rst = 1'b0;
        tick(3);
        // first commit after reset pulses even for zero
        base = fv_cnt;
        frame(0, 0, 0, 0);
        chk("zero_one_frame", 16'(fv_cnt - base), 16'd0);
        frame(0, 0, 0, 0);
        chk("zero_first_commit", 16'(fv_cnt - base), 16'd1);
        chk("zero_bcd", bcd_value, 16'h0000);
        // 9999 with binary output timing
        frame(9, 9, 9, 9);
        digit(0, 9);
        digit(1, 9);
        digit(2, 9);
        an_scan = 4'b0111;
        num = 4'd9;
        tick(1);
        chk("9999_edge1_fv", {15'd0, frame_valid}, 16'd0);
        tick(1);
        chk("9999_fv", {15'd0, frame_valid}, 16'd1);
        chk("bcd_9999", bcd_value, 16'h9999);
`ifdef SCAN_CAPTURE_BIN_OUT_EN
        chk("binv_not_yet", {15'd0, bin_valid}, 16'd0);
`endif
        an_scan = 4'hF;
        tick(1);
        chk("9999_fv_drop", {15'd0, frame_valid}, 16'd0);
`ifdef SCAN_CAPTURE_BIN_OUT_EN
        chk("binv_pulse", {15'd0, bin_valid}, 16'd1);
        chk("bin_9999", {2'd0, bin_value}, 16'd9999);
        tick(1);
        chk("binv_drop", {15'd0, bin_valid}, 16'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
